// File: rtl/usb_rx_reader.sv
// usb_rx_reader: FT600-style synchronous 245-FIFO read master.
// Drives usb_outen_l / usb_rden_l and samples first-word-fall-through data.
// Buffers the words in a small circular skid FIFO and presents them as a
// valid/ready stream.
// Optional feature macro: USB_RX_BE_CHECK_EN. When it is defined, captured
// words whose byte enables are not 4'hF are dropped and counted in
// be_err_cnt. When it is undefined, usb_be_i is ignored and be_err_cnt is 0.

// Occupancy checker: the skid FIFO must never overflow or underflow.
module usb_rx_reader_chk #(
  parameter int SKID_DEPTH = 4,
  parameter int FILL_W     = 3
) (
  input logic              clk,
  input logic              rst_l,
  input logic              push,
  input logic              pop,
  input logic [FILL_W-1:0] fill
);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SKID_DEPTH);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_l)
    !(push && !pop && (fill == FILL_FULL)));

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_l)
    !(pop && (fill == '0)));

  a_fill_bound: assert property (@(posedge clk) disable iff (!rst_l)
    (fill <= FILL_FULL));
endmodule

module usb_rx_reader #(
  parameter int WIDTH      = 32,
  parameter int SKID_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic [WIDTH-1:0] usb_data_i,
  input  logic [3:0]       usb_be_i,
  input  logic             usb_rx_empty,
  input  logic             tx_busy,
  output logic             usb_outen_l,
  output logic             usb_rden_l,
  output logic             rx_busy,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [15:0]      be_err_cnt
);
  localparam int PTR_W  = $clog2(SKID_DEPTH);
  localparam int FILL_W = PTR_W + 1;
  // A burst may only start while at least two slots are free.
  localparam logic [FILL_W-1:0] FILL_ARB  = FILL_W'(SKID_DEPTH - 2);
  // Once this many words are held, the current edge is the last read edge.
  localparam logic [FILL_W-1:0] FILL_STOP = FILL_W'(SKID_DEPTH - 1);
  localparam logic [FILL_W-1:0] FILL_ZERO = '0;
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1'b1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OE   = 2'd1,
    ST_READ = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              outen_nxt_s;
  logic              rden_nxt_s;
  logic              usb_outen_l_r;
  logic              usb_rden_l_r;
  logic              rx_busy_r;

  logic [WIDTH-1:0]  mem_r [SKID_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [FILL_W-1:0] fill_r;

  logic              capture_s;
  logic              be_ok_s;
  logic              push_s;
  logic              pop_s;

  // Next-state logic of the bus FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!usb_rx_empty && !tx_busy && (fill_r <= FILL_ARB)) begin
          state_nxt_s = ST_OE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_OE: begin
        state_nxt_s = ST_READ;
      end
      ST_READ: begin
        if (usb_rx_empty || (fill_r >= FILL_STOP)) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_READ;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Bus strobe values for the state being entered, so the strobes can be registered.
  always_comb begin
    outen_nxt_s = 1'b1;
    rden_nxt_s  = 1'b1;
    case (state_nxt_s)
      ST_OE: begin
        outen_nxt_s = 1'b0;
        rden_nxt_s  = 1'b1;
      end
      ST_READ: begin
        outen_nxt_s = 1'b0;
        rden_nxt_s  = 1'b0;
      end
      default: begin
        outen_nxt_s = 1'b1;
        rden_nxt_s  = 1'b1;
      end
    endcase
  end

  // State register and glitch-free registered bus strobes.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_r       <= ST_IDLE;
      usb_outen_l_r <= 1'b1;
      usb_rden_l_r  <= 1'b1;
      rx_busy_r     <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      usb_outen_l_r <= outen_nxt_s;
      usb_rden_l_r  <= rden_nxt_s;
      rx_busy_r     <= (state_nxt_s != ST_IDLE);
    end
  end

  // FWFT: the word on the bus is valid on any read edge while data remains.
  assign capture_s = (state_r == ST_READ) && !usb_rden_l_r && !usb_rx_empty;
  assign push_s    = capture_s && be_ok_s;
  assign pop_s     = (fill_r != FILL_ZERO) && m_ready;

  // Skid FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      fill_r   <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= usb_data_i;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   fill_r <= fill_r + FILL_ONE;
        2'b01:   fill_r <= fill_r - FILL_ONE;
        default: fill_r <= fill_r;
      endcase
    end
  end

  assign usb_outen_l = usb_outen_l_r;
  assign usb_rden_l  = usb_rden_l_r;
  assign rx_busy     = rx_busy_r;
  assign m_valid     = (fill_r != FILL_ZERO);
  assign m_data      = mem_r[rd_ptr_r];

`ifdef USB_RX_BE_CHECK_EN
  logic [15:0] be_err_cnt_r;

  assign be_ok_s = (usb_be_i == 4'hF);

  // Saturating count of captured words dropped for partial byte enables.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      be_err_cnt_r <= 16'h0000;
    end else if (capture_s && !be_ok_s && (be_err_cnt_r != 16'hFFFF)) begin
      be_err_cnt_r <= be_err_cnt_r + 16'h0001;
    end else begin
      be_err_cnt_r <= be_err_cnt_r;
    end
  end

  assign be_err_cnt = be_err_cnt_r;
`else
  logic [3:0] be_unused_s;

  assign be_unused_s = usb_be_i;
  assign be_ok_s     = 1'b1;
  assign be_err_cnt  = 16'h0000;
`endif

  usb_rx_reader_chk #(
    .SKID_DEPTH (SKID_DEPTH),
    .FILL_W     (FILL_W)
  ) u_chk (
    .clk   (clk),
    .rst_l (rst_l),
    .push  (push_s),
    .pop   (pop_s),
    .fill  (fill_r)
  );
endmodule

// File: tb/tb_usb_rx_reader.sv
// Testbench for usb_rx_reader: a mock FT600 FWFT FIFO feeds the bus pins,
// expected words are queued when loaded into the mock and a negedge monitor
// compares every accepted stream word against the queue head.
module tb_usb_rx_reader;
  logic        clk = 1'b0;
  logic        rst_l;
  logic [31:0] usb_data_i;
  logic [3:0]  usb_be_i;
  logic        usb_rx_empty;
  logic        tx_busy;
  logic        usb_outen_l;
  logic        usb_rden_l;
  logic        rx_busy;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] be_err_cnt;

  logic [31:0] mock_mem [256];
  logic [3:0]  mock_be  [256];
  int          mock_wr = 0;
  int          mock_rd = 0;
  logic [31:0] exp_q [$];
  int          n_checks = 0;
  int          n_pass   = 0;

  usb_rx_reader #(.WIDTH(32), .SKID_DEPTH(4)) dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .usb_data_i   (usb_data_i),
    .usb_be_i     (usb_be_i),
    .usb_rx_empty (usb_rx_empty),
    .tx_busy      (tx_busy),
    .usb_outen_l  (usb_outen_l),
    .usb_rden_l   (usb_rden_l),
    .rx_busy      (rx_busy),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .be_err_cnt   (be_err_cnt)
  );

  always #5 clk = ~clk;

  // Mock FT600: FWFT word is visible while output enable is low.
  assign usb_rx_empty = (mock_rd == mock_wr);
  assign usb_data_i   = usb_outen_l ? 32'h0 : mock_mem[mock_rd[7:0]];
  assign usb_be_i     = usb_outen_l ? 4'h0 : mock_be[mock_rd[7:0]];

  // Mock FT600 advances to the next word on every read strobe edge.
  always @(posedge clk) begin
    if (!usb_rden_l && !usb_rx_empty) mock_rd <= mock_rd + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Scoreboard monitor: every accepted word must match the queue head.
  always @(negedge clk) begin
    if (rst_l && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL stream_extra: got word %h, expected no word", m_data);
      end else begin
        check("stream_word", m_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] d, input logic [3:0] be);
    mock_mem[mock_wr[7:0]] = d;
    mock_be[mock_wr[7:0]]  = be;
`ifdef USB_RX_BE_CHECK_EN
    if (be == 4'hF) exp_q.push_back(d);
`else
    exp_q.push_back(d);
`endif
    mock_wr++;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || !usb_rx_empty || rx_busy) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check({name, "_mock_drained"}, 32'(mock_rd), 32'(mock_wr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int base;
    logic [15:0] exp_be_cnt;
    rst_l   = 1'b0;
    tx_busy = 1'b0;
    m_ready = 1'b1;
    tick();
    tick();
    // Reset state
    check("rst_outen", 32'(usb_outen_l), 32'd1);
    check("rst_rden", 32'(usb_rden_l), 32'd1);
    check("rst_busy", 32'(rx_busy), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data", m_data, 32'd0);
    check("rst_becnt", 32'(be_err_cnt), 32'd0);
    rst_l = 1'b1;
    tick();

    // Test 1: 8-word burst with m_ready=1
    for (int i = 0; i < 8; i++) load_word(32'hA5C3_0000 + 32'(i) * 32'h0001_1111, 4'hF);
    n = 0;
    while (usb_outen_l && n < 20) begin tick(); n++; end
    check("t1_oe_low", 32'(usb_outen_l), 32'd0);
    check("t1_rden_still_high", 32'(usb_rden_l), 32'd1);
    tick();
    check("t1_rden_low", 32'(usb_rden_l), 32'd0);
    n = 0;
    while (!usb_rx_empty && n < 40) begin tick(); n++; end
    check("t1_rden_low_at_empty", 32'(usb_rden_l), 32'd0);
    tick();
    check("t1_rden_high_after_empty", 32'(usb_rden_l), 32'd1);
    check("t1_outen_high_done", 32'(usb_outen_l), 32'd1);
    check("t1_busy_done", 32'(rx_busy), 32'd1);
    tick();
    check("t1_idle", 32'(rx_busy), 32'd0);
    drain("t1", 40);

    // Test 2: router stalled, burst must stop with the FIFO full
    m_ready = 1'b0;
    base = mock_rd;
    for (int i = 0; i < 8; i++) load_word(32'h5A00_F000 ^ (32'(i) << 20), 4'hF);
    for (int i = 0; i < 15; i++) tick();
    check("t2_words_read", 32'(mock_rd - base), 32'd4);
    check("t2_idle", 32'(rx_busy), 32'd0);
    check("t2_outen", 32'(usb_outen_l), 32'd1);
    check("t2_rden", 32'(usb_rden_l), 32'd1);
    check("t2_valid", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    drain("t2", 100);

    // Test 3: 16 words with m_ready toggling every cycle
    for (int i = 0; i < 16; i++) load_word(32'h3300_0000 + 32'(i) * 32'h0001_0101, 4'hF);
    n = 0;
    while ((exp_q.size() != 0 || !usb_rx_empty || rx_busy) && n < 400) begin
      m_ready = ~m_ready;
      tick();
      n++;
    end
    m_ready = 1'b1;
    drain("t3", 20);

    // Test 4: tx_busy holds off the burst; raising it mid-burst is ignored
    tx_busy = 1'b1;
    for (int i = 0; i < 4; i++) load_word(32'hDEAD_0000 | 32'(i + 1), 4'hF);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_outen", 32'(usb_outen_l), 32'd1);
      check("t4_hold_rden", 32'(usb_rden_l), 32'd1);
    end
    check("t4_hold_busy", 32'(rx_busy), 32'd0);
    tx_busy = 1'b0;
    tick();
    check("t4_oe_after_release", 32'(usb_outen_l), 32'd0);
    tick();
    check("t4_read", 32'(usb_rden_l), 32'd0);
    tx_busy = 1'b1;
    drain("t4", 60);
    tx_busy = 1'b0;

    // Test 5: asynchronous reset during READ
    for (int i = 0; i < 8; i++) load_word(32'h0BAD_C000 + 32'(i) * 32'h0000_0011, 4'hF);
    n = 0;
    while (usb_rden_l && n < 20) begin tick(); n++; end
    check("t5_read_entered", 32'(usb_rden_l), 32'd0);
    tick();
    tick();
    rst_l = 1'b0;
    #1;
    check("t5_rst_outen", 32'(usb_outen_l), 32'd1);
    check("t5_rst_rden", 32'(usb_rden_l), 32'd1);
    check("t5_rst_valid", 32'(m_valid), 32'd0);
    check("t5_rst_busy", 32'(rx_busy), 32'd0);
    // Words already taken from the mock are lost; the rest must still arrive.
    exp_q.delete();
    for (int i = mock_rd; i < mock_wr; i++) exp_q.push_back(mock_mem[8'(i)]);
    tick();
    tick();
    rst_l = 1'b1;
    drain("t5", 100);

    // Test 6: word 3 of 5 with partial byte enables
    for (int i = 0; i < 5; i++) load_word(32'h6600_0006 + (32'(i) << 8), (i == 2) ? 4'h3 : 4'hF);
    drain("t6", 60);
`ifdef USB_RX_BE_CHECK_EN
    exp_be_cnt = 16'd1;
`else
    exp_be_cnt = 16'd0;
`endif
    check("t6_be_err_cnt", 32'(be_err_cnt), 32'(exp_be_cnt));

    tick();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
